// File: rtl/pe.sv
// Processing element for a weight-stationary systolic array.
// Holds one stationary weight, multiplies the activation arriving from the left
// by that weight and adds the partial sum arriving from above. Activation, sum and
// valid flag are registered and forwarded right/down with one cycle of latency.
module pe #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DATA_W_OUT = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [DATA_W-1:0]     in_act,
  input  logic [DATA_W_OUT-1:0] in_psum,
  input  logic [DATA_W-1:0]     weight_load,
  input  logic                  load_w,
  output logic [DATA_W-1:0]     out_act,
  output logic [DATA_W_OUT-1:0] out_psum,
  output logic                  valid_out
);

  localparam int unsigned ProdW = 2 * DATA_W;

  // The sign extension below relies on the sum being at least as wide as the product.
  if (DATA_W_OUT < ProdW) begin : gen_width_check
    $error("pe: DATA_W_OUT must be at least 2*DATA_W");
  end

  logic [DATA_W-1:0]     w_q, w_d;
  logic [DATA_W-1:0]     act_q, act_d;
  logic [DATA_W_OUT-1:0] psum_q, psum_d;
  logic                  valid_q, valid_d;

  logic signed [ProdW-1:0]      prod;
  logic signed [DATA_W_OUT-1:0] prod_ext;
  logic        [DATA_W_OUT-1:0] mac_sum;

  // Full-precision signed product, sign-extended, then a wrapping add.
  always_comb begin
    prod     = $signed(in_act) * $signed(w_q);
    prod_ext = DATA_W_OUT'(prod);
    mac_sum  = in_psum + DATA_W_OUT'(prod_ext);
  end

  // Next state: weight load takes priority over compute; idle holds data, drops valid.
  always_comb begin
    w_d     = w_q;
    act_d   = act_q;
    psum_d  = psum_q;
    valid_d = 1'b0;
    if (load_w) begin
      w_d = weight_load;
    end else if (valid_in) begin
      act_d   = in_act;
      psum_d  = mac_sum;
      valid_d = 1'b1;
    end
  end

  // State registers, cleared asynchronously (weight included).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q     <= '0;
      act_q   <= '0;
      psum_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      w_q     <= w_d;
      act_q   <= act_d;
      psum_q  <= psum_d;
      valid_q <= valid_d;
    end
  end

  // Outputs come straight from registers; no input-to-output path.
  always_comb begin
    out_act   = act_q;
    out_psum  = psum_q;
    valid_out = valid_q;
  end

endmodule

// File: tb/tb_pe.sv
// Directed plus random bench for pe with an expected-result queue.
module tb_pe;

  localparam int unsigned DW  = 8;
  localparam int unsigned DWO = 31;

  logic           clk;
  logic           rst_n;
  logic           valid_in;
  logic [DW-1:0]  in_act;
  logic [DWO-1:0] in_psum;
  logic [DW-1:0]  weight_load;
  logic           load_w;
  logic [DW-1:0]  out_act;
  logic [DWO-1:0] out_psum;
  logic           valid_out;

  pe #(.DATA_W(DW), .DATA_W_OUT(DWO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .in_act     (in_act),
    .in_psum    (in_psum),
    .weight_load(weight_load),
    .load_w     (load_w),
    .out_act    (out_act),
    .out_psum   (out_psum),
    .valid_out  (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]  act;
    logic [DWO-1:0] psum;
    logic           valid;
  } exp_t;

  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference state kept by the bench.
  logic [DW-1:0]  m_w;
  logic [DW-1:0]  m_act;
  logic [DWO-1:0] m_psum;
  logic           m_valid;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_w = '0; m_act = '0; m_psum = '0; m_valid = 1'b0;
  endtask

  // Drive one cycle of stimulus, push the expected outputs, then pop and compare.
  task automatic step(input logic ld, input logic [DW-1:0] w, input logic vin,
                      input logic [DW-1:0] act, input logic [DWO-1:0] psum);
    exp_t e;
    longint p;
    @(negedge clk);
    load_w = ld; weight_load = w; valid_in = vin; in_act = act; in_psum = psum;
    if (ld) begin
      m_w = w;
      m_valid = 1'b0;
    end else if (vin) begin
      p = longint'($signed(act)) * longint'($signed(m_w));
      m_act = act;
      m_psum = psum + DWO'(p);
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    e.act = m_act; e.psum = m_psum; e.valid = m_valid;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("sb_act", 64'(out_act), 64'(e.act));
    check("sb_psum", 64'(out_psum), 64'(e.psum));
    check("sb_valid", 64'(valid_out), 64'(e.valid));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_act"}, 64'(out_act), 64'd0);
    check({tag, "_psum"}, 64'(out_psum), 64'd0);
    check({tag, "_valid"}, 64'(valid_out), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; in_act = '0; in_psum = '0;
    weight_load = '0; load_w = 1'b0;
    model_reset();
    #2;
    check_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Load then compute: 9*5 + 55 = 100.
    step(1'b1, 8'd5, 1'b0, 8'd0, 31'd0);
    step(1'b0, 8'd0, 1'b1, 8'd9, 31'd55);
    check("lc_psum", $signed(out_psum), 64'sd100);
    check("lc_act", 64'(out_act), 64'd9);

    // Signed math.
    step(1'b1, 8'hFD, 1'b0, 8'd0, 31'd0);
    step(1'b0, 8'd0, 1'b1, 8'd7, 31'd10);
    check("neg_psum", $signed(out_psum), -64'sd11);
    step(1'b1, 8'h80, 1'b0, 8'd0, 31'd0);
    step(1'b0, 8'd0, 1'b1, 8'h80, 31'd0);
    check("minmin_psum", $signed(out_psum), 64'sd16384);

    // Streaming with a bubble.
    step(1'b1, 8'd2, 1'b0, 8'd0, 31'd0);
    step(1'b0, 8'd0, 1'b1, 8'd1, 31'd0);
    check("st1", $signed(out_psum), 64'sd2);
    step(1'b0, 8'd0, 1'b1, 8'd2, 31'd0);
    check("st2", $signed(out_psum), 64'sd4);
    step(1'b0, 8'd0, 1'b1, 8'd3, 31'd0);
    check("st3", $signed(out_psum), 64'sd6);
    step(1'b0, 8'd0, 1'b0, 8'd77, 31'd99);
    check("bubble_valid", 64'(valid_out), 64'd0);
    check("bubble_psum", $signed(out_psum), 64'sd6);

    // Load priority over compute.
    step(1'b1, 8'd4, 1'b1, 8'd50, 31'd1000);
    check("prio_valid", 64'(valid_out), 64'd0);
    check("prio_psum", $signed(out_psum), 64'sd6);
    step(1'b0, 8'd0, 1'b1, 8'd3, 31'd0);
    check("prio_next", $signed(out_psum), 64'sd12);

    // Wrap-around: (2^30 - 1) + 1 -> -2^30.
    step(1'b1, 8'd1, 1'b0, 8'd0, 31'd0);
    step(1'b0, 8'd0, 1'b1, 8'd1, 31'h3FFF_FFFF);
    check("wrap_psum", $signed(out_psum), -64'sd1073741824);

    // Weight persists across idle cycles.
    for (int i = 0; i < 3; i++) step(1'b0, 8'd9, 1'b0, 8'd0, 31'd0);
    step(1'b0, 8'd9, 1'b1, 8'hFE, 31'd5);
    check("persist_psum", $signed(out_psum), 64'sd3);

    // Random mix.
    for (int i = 0; i < 40; i++) begin
      step(($urandom_range(0, 5) == 0), 8'($urandom), ($urandom_range(0, 3) != 0),
           8'($urandom), 31'($urandom));
    end

    // Reset mid-cycle clears outputs immediately and holds them at zero.
    step(1'b1, 8'd7, 1'b0, 8'd0, 31'd0);
    step(1'b0, 8'd0, 1'b1, 8'd11, 31'd3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero("rst_mid");
    @(posedge clk);
    #1;
    check_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    // Weight was cleared: product is zero, sum passes through.
    step(1'b0, 8'd0, 1'b1, 8'd5, 31'd42);
    check("post_rst_psum", $signed(out_psum), 64'sd42);
    check("post_rst_valid", 64'(valid_out), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pe.md
# pe

Processing element for the weight-stationary systolic array in the MobileViT accelerator. Each PE holds one stationary weight, multiplies the activation arriving from its left neighbour by that weight, and adds the partial sum arriving from above. The activation is registered and forwarded to the right, the accumulated sum is forwarded down, and a valid flag travels with the data. PEs tile into an R×C grid: `out_act` feeds the right neighbour's `in_act`, and `out_psum` feeds the lower neighbour's `in_psum`.

## Interface
- `DATA_W`, default 8: activation and weight width, signed two's complement.
- `DATA_W_OUT`, default 31: partial-sum width, signed two's complement; must be ≥ 2·DATA_W.

- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `valid_in`: input, 1 bit. `in_act` and `in_psum` are valid this cycle.
- `in_act`: input, DATA_W bits. Activation from the left.
- `in_psum`: input, DATA_W_OUT bits. Partial sum from above.
- `weight_load`: input, DATA_W bits. New weight value; sampled only when `load_w`=1.
- `load_w`: input, 1 bit. Weight-load enable.
- `out_act`: output, DATA_W bits. Registered activation, forwarded right.
- `out_psum`: output, DATA_W_OUT bits. Registered partial sum, forwarded down.
- `valid_out`: output, 1 bit. Registered valid flag for `out_act` and `out_psum`.

## Operation
- **Internal registers:** `W_reg` (DATA_W), `act_reg` (DATA_W), `psum_reg` (DATA_W_OUT), `valid_reg` (1).
- **Output mapping:** `out_act`=`act_reg`, `out_psum`=`psum_reg`, `valid_out`=`valid_reg`. No combinational path from any input to any output.
- **Reset** (`rst_n`=0, asynchronous): all four registers clear to 0. Outputs read 0 immediately and stay 0 while reset is held.
- **Load cycle** (`load_w`=1):
  - `W_reg` ← `weight_load`.
  - Load has priority over compute, so no MAC occurs this cycle, even if `valid_in`=1.
  - `valid_reg` ← 0; `act_reg` and `psum_reg` hold.
- **Compute cycle** (`load_w`=0, `valid_in`=1):
  - `act_reg` ← `in_act`.
  - `psum_reg` ← `in_psum` + sext(`in_act` × `W_reg`), using the weight value present before this edge.
  - `valid_reg` ← 1.
- **Idle cycle** (`load_w`=0, `valid_in`=0):
  - `act_reg`, `psum_reg` and `W_reg` hold.
  - `valid_reg` ← 0.
- **Arithmetic:**
  - The product is a full-precision signed 2·DATA_W-bit value, sign-extended to DATA_W_OUT before the add.
  - The sum wraps modulo 2^DATA_W_OUT. No saturation and no overflow flag.
- **Weight persistence:** `W_reg` keeps its value across any number of compute and idle cycles until the next `load_w` or reset.

## Timing
- **Latency:** 1 cycle. Inputs sampled at edge N appear on outputs after edge N and are stable for the whole of cycle N+1.
- **Weight availability:** a weight loaded at edge N is used by a compute at edge N+1 at the earliest.
- **Throughput:** one MAC per cycle when `valid_in` is held high and `load_w` is low.
- **No backpressure:** there is no ready signal. Downstream must accept every cycle that `valid_out`=1.
- **Reset mid-operation:** clears everything, including `W_reg`. The weight must be reloaded before valid results are produced.
- **Reset release:** the first rising edge after `rst_n` rises behaves as a normal edge.

## Test plan
- **Reset:** assert `rst_n`=0 mid-cycle -> `out_act`=0, `out_psum`=0 and `valid_out`=0 immediately, without waiting for a clock edge.
- **Load then compute:**
  - Edge 1: `load_w`=1, `weight_load`=5 -> `W_reg`=5, `valid_out`=0.
  - Edge 2: `load_w`=0, `valid_in`=1, `in_act`=9, `in_psum`=55 -> after the edge, `out_act`=9, `out_psum`=100, `valid_out`=1.
- **Signed math:** W=-3, `in_act`=7, `in_psum`=10 -> `out_psum`=-11. W=-128, `in_act`=-128, `in_psum`=0 -> `out_psum`=16384.
- **Streaming with bubble:**
  - With W=2, drive acts 1,2,3 on consecutive cycles with `in_psum`=0 -> outputs 2,4,6, one cycle later each, `valid_out`=1 throughout.
  - Follow with one `valid_in`=0 cycle -> `valid_out`=0 while `out_psum` holds 6.
- **Load priority:** `load_w`=1, `valid_in`=1 and `weight_load`=4 in the same cycle -> `valid_out`=0 and `psum_reg` unchanged. The next compute with `in_act`=3, `in_psum`=0 gives `out_psum`=12.
- **Wrap-around:** with DATA_W_OUT=31, `in_psum`=2^30−1, W=1, `in_act`=1 -> `out_psum`=−2^30, i.e. two's-complement wrap.
